// File: rtl/slave_rx_sink.sv
// Purpose: captures one received serial message into a byte buffer and holds it for the host.
// Latency: rx_rdy_wr one cycle after a write request is sampled; host_rd_data one cycle after address.
// Backpressure: none toward the receiver; while a message is held, new traffic is acked and dropped (overrun).
module slave_rx_sink #(
  parameter int ADDR_W  = 8,
  parameter int MAX_LEN = 256
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic [7:0]        rx_flag,
  input  logic [15:0]       rx_byte_number,
  input  logic              rx_hdr_en,
  input  logic              rx_req_wr,
  output logic              rx_rdy_wr,
  input  logic [15:0]       rx_addr,
  input  logic [7:0]        rx_data,
  input  logic              rx_end,
  input  logic              rx_right,
  input  logic              rx_line,
  input  logic [ADDR_W-1:0] host_rd_addr,
  output logic [7:0]        host_rd_data,
  input  logic              host_ack,
  output logic              msg_valid,
  output logic [7:0]        msg_flag,
  output logic [15:0]       msg_len,
  output logic              msg_line,
  output logic [7:0]        err_cnt,
  output logic              overrun
);

  localparam logic [15:0] MAX_CNT = 16'(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_HOLD} state_t;

  state_t      state, state_nxt;
  logic [7:0]  mem [0:(1<<ADDR_W)-1];
  logic [7:0]  lat_flag;
  logic [15:0] lat_len;
  logic [15:0] wr_cnt;
  logic        bad;
  logic        armed;

  logic        accept, in_msg, msg_wr, addr_ok, cnt_full, wr_mem, bad_next;
  logic [15:0] cnt_next;
  logic        end_chk, commit, reject, start_idle, restart, load_hdr;
  logic        release_msg, err_inc, ovr_set;

  // Addresses beyond the buffer are flagged rather than aliased into it.
  assign addr_ok = ((rx_addr >> ADDR_W) == 16'd0);

  // Decode this cycle's events and the next state; a write landing with rx_end counts before the commit check.
  always_comb begin
    accept      = rx_req_wr && armed;
    in_msg      = (state == S_RECV) || (state == S_WRITE);
    msg_wr      = accept && (state == S_RECV);
    cnt_full    = (wr_cnt >= MAX_CNT);
    wr_mem      = msg_wr && addr_ok && !cnt_full;
    bad_next    = bad || (msg_wr && (!addr_ok || cnt_full));
    cnt_next    = (msg_wr && !cnt_full) ? (wr_cnt + 16'd1) : wr_cnt;
    end_chk     = rx_end && in_msg;
    commit      = end_chk && rx_right && !bad_next && (cnt_next == lat_len);
    reject      = end_chk && !commit;
    start_idle  = rx_hdr_en && (state == S_IDLE);
    restart     = rx_hdr_en && in_msg && !rx_end;
    load_hdr    = start_idle || restart;
    release_msg = host_ack && (state == S_HOLD);
    err_inc     = reject || restart || (rx_end && (state == S_HOLD));
    ovr_set     = (state == S_HOLD) && (rx_hdr_en || accept);
    state_nxt   = state;
    case (state)
      S_IDLE:  if (start_idle) state_nxt = S_RECV;
      S_RECV: begin
        if (commit)       state_nxt = S_HOLD;
        else if (reject)  state_nxt = S_IDLE;
        else if (restart) state_nxt = S_RECV;
        else if (msg_wr)  state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (commit)      state_nxt = S_HOLD;
        else if (reject) state_nxt = S_IDLE;
        else             state_nxt = S_RECV;
      end
      S_HOLD:  if (release_msg) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_l) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Message buffer; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_mem) mem[rx_addr[ADDR_W-1:0]] <= rx_data;
  end

  // Registered host read port; a same-cycle write to the address returns the previous byte.
  always_ff @(posedge clk) begin
    if (!rst_l) host_rd_data <= 8'h00;
    else        host_rd_data <= mem[host_rd_addr];
  end

  // Handshake, message bookkeeping and status registers.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      armed     <= 1'b1;
      rx_rdy_wr <= 1'b0;
      lat_flag  <= 8'h00;
      lat_len   <= 16'h0000;
      wr_cnt    <= 16'h0000;
      bad       <= 1'b0;
      msg_valid <= 1'b0;
      msg_flag  <= 8'h00;
      msg_len   <= 16'h0000;
      msg_line  <= 1'b0;
      err_cnt   <= 8'h00;
      overrun   <= 1'b0;
    end else begin
      // A request level is served once; it must drop before the next one is taken.
      if (!rx_req_wr)  armed <= 1'b1;
      else if (accept) armed <= 1'b0;
      rx_rdy_wr <= accept;
      if (load_hdr) begin
        lat_flag <= rx_flag;
        lat_len  <= rx_byte_number;
        wr_cnt   <= 16'h0000;
        bad      <= 1'b0;
      end else begin
        wr_cnt <= cnt_next;
        bad    <= bad_next;
      end
      if (commit) begin
        msg_valid <= 1'b1;
        msg_flag  <= lat_flag;
        msg_len   <= cnt_next;
        msg_line  <= rx_line;
      end else if (release_msg) begin
        msg_valid <= 1'b0;
      end
      if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      if (ovr_set) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_slave_rx_sink.sv
// Purpose: directed self-checking bench for slave_rx_sink.
// Latency: checks sample 1 ns after each rising edge.
// Backpressure: the bench acts as receiver and host; it never stalls the DUT.
module tb_slave_rx_sink;
  localparam int ADDR_W  = 8;
  localparam int MAX_LEN = 256;

  logic              clk = 1'b0;
  logic              rst_l;
  logic [7:0]        rx_flag;
  logic [15:0]       rx_byte_number;
  logic              rx_hdr_en;
  logic              rx_req_wr;
  logic              rx_rdy_wr;
  logic [15:0]       rx_addr;
  logic [7:0]        rx_data;
  logic              rx_end;
  logic              rx_right;
  logic              rx_line;
  logic [ADDR_W-1:0] host_rd_addr;
  logic [7:0]        host_rd_data;
  logic              host_ack;
  logic              msg_valid;
  logic [7:0]        msg_flag;
  logic [15:0]       msg_len;
  logic              msg_line;
  logic [7:0]        err_cnt;
  logic              overrun;

  int errors = 0;
  int checks = 0;

  slave_rx_sink #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst_l(rst_l),
    .rx_flag(rx_flag), .rx_byte_number(rx_byte_number), .rx_hdr_en(rx_hdr_en),
    .rx_req_wr(rx_req_wr), .rx_rdy_wr(rx_rdy_wr), .rx_addr(rx_addr), .rx_data(rx_data),
    .rx_end(rx_end), .rx_right(rx_right), .rx_line(rx_line),
    .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data), .host_ack(host_ack),
    .msg_valid(msg_valid), .msg_flag(msg_flag), .msg_len(msg_len), .msg_line(msg_line),
    .err_cnt(err_cnt), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [7:0] flag, input logic [15:0] len);
    rx_flag = flag; rx_byte_number = len; rx_hdr_en = 1'b1;
    tick();
    rx_hdr_en = 1'b0;
  endtask

  // One request level, then drop it; returns how many rx_rdy_wr cycles were seen.
  task automatic do_write(input logic [15:0] a, input logic [7:0] d, output int pulses);
    pulses = 0;
    rx_addr = a; rx_data = d; rx_req_wr = 1'b1;
    tick();
    if (rx_rdy_wr === 1'b1) pulses++;
    rx_req_wr = 1'b0;
    tick();
    if (rx_rdy_wr === 1'b1) pulses++;
  endtask

  task automatic send_end(input logic right, input logic line);
    rx_end = 1'b1; rx_right = right; rx_line = line;
    tick();
    rx_end = 1'b0; rx_right = 1'b0; rx_line = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    host_rd_addr = a;
    tick();
  endtask

  task automatic ack();
    host_ack = 1'b1;
    tick();
    host_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_l = 1'b0;
    tick(); tick();
    checks++; if (rx_rdy_wr !== 1'b0) begin errors++; $display("FAIL rst_rdy: got %0h want 0", rx_rdy_wr); end
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0h want 0", msg_valid); end
    checks++; if (msg_flag !== 8'h00) begin errors++; $display("FAIL rst_flag: got %0h want 0", msg_flag); end
    checks++; if (msg_len !== 16'h0000) begin errors++; $display("FAIL rst_len: got %0h want 0", msg_len); end
    checks++; if (msg_line !== 1'b0) begin errors++; $display("FAIL rst_line: got %0h want 0", msg_line); end
    checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL rst_err: got %0h want 0", err_cnt); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr: got %0h want 0", overrun); end
    checks++; if (host_rd_data !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %0h want 0", host_rd_data); end
    rst_l = 1'b1;
    tick();
  endtask

  task automatic test_good_msg();
    logic [7:0] vals [4];
    int p, tot;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    tot = 0;
    send_hdr(8'h5A, 16'd4);
    for (int i = 0; i < 4; i++) begin
      do_write(16'(i), vals[i], p);
      tot += p;
    end
    checks++; if (tot != 4) begin errors++; $display("FAIL good_pulses: got %0d want 4", tot); end
    send_end(1'b1, 1'b1);
    checks++; if (msg_valid !== 1'b1) begin errors++; $display("FAIL good_valid: got %0h want 1", msg_valid); end
    checks++; if (msg_len !== 16'd4) begin errors++; $display("FAIL good_len: got %0h want 4", msg_len); end
    checks++; if (msg_flag !== 8'h5A) begin errors++; $display("FAIL good_flag: got %0h want 5a", msg_flag); end
    checks++; if (msg_line !== 1'b1) begin errors++; $display("FAIL good_line: got %0h want 1", msg_line); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL good_err: got %0h want 0", err_cnt); end
    for (int i = 0; i < 4; i++) begin
      rd(ADDR_W'(i));
      checks++; if (host_rd_data !== vals[i]) begin errors++; $display("FAIL good_rd%0d: got %0h want %0h", i, host_rd_data, vals[i]); end
    end
    ack();
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL good_ack: got %0h want 0", msg_valid); end
  endtask

  task automatic test_len_mismatch();
    int p;
    send_hdr(8'hA0, 16'd4);
    do_write(16'd4, 8'h01, p);
    do_write(16'd5, 8'h02, p);
    do_write(16'd6, 8'h03, p);
    send_end(1'b1, 1'b0);
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL mis_valid: got %0h want 0", msg_valid); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL mis_err: got %0h want 1", err_cnt); end
    checks++; if (msg_len !== 16'd4) begin errors++; $display("FAIL mis_len_kept: got %0h want 4", msg_len); end
  endtask

  task automatic test_held_req();
    logic [4:0] seen;
    send_hdr(8'h33, 16'd1);
    rx_addr = 16'd8; rx_data = 8'h99; rx_req_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen[i] = rx_rdy_wr;
    end
    rx_req_wr = 1'b0;
    tick();
    checks++; if (seen !== 5'b00001) begin errors++; $display("FAIL held_pulse: got %b want 00001", seen); end
    send_end(1'b1, 1'b0);
    checks++; if (msg_valid !== 1'b1) begin errors++; $display("FAIL held_valid: got %0h want 1", msg_valid); end
    checks++; if (msg_len !== 16'd1) begin errors++; $display("FAIL held_len: got %0h want 1", msg_len); end
    checks++; if (msg_flag !== 8'h33) begin errors++; $display("FAIL held_flag: got %0h want 33", msg_flag); end
    checks++; if (msg_line !== 1'b0) begin errors++; $display("FAIL held_line: got %0h want 0", msg_line); end
    rd(8'd8);
    checks++; if (host_rd_data !== 8'h99) begin errors++; $display("FAIL held_rd: got %0h want 99", host_rd_data); end
  endtask

  // Entered with the held-request message still committed.
  task automatic test_overrun();
    int p, tot;
    send_hdr(8'h77, 16'd2);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %0h want 1", overrun); end
    do_write(16'd8, 8'hEE, p); tot = p;
    do_write(16'd9, 8'hFF, p); tot += p;
    checks++; if (tot != 2) begin errors++; $display("FAIL ovr_pulses: got %0d want 2", tot); end
    rd(8'd8);
    checks++; if (host_rd_data !== 8'h99) begin errors++; $display("FAIL ovr_buf: got %0h want 99", host_rd_data); end
    checks++; if (msg_len !== 16'd1) begin errors++; $display("FAIL ovr_len: got %0h want 1", msg_len); end
    ack();
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL ovr_ack: got %0h want 0", msg_valid); end
    send_hdr(8'h42, 16'd1);
    do_write(16'd10, 8'h42, p);
    send_end(1'b1, 1'b1);
    checks++; if (msg_valid !== 1'b1) begin errors++; $display("FAIL ovr_idle: got %0h want 1", msg_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %0h want 1", overrun); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL ovr_err: got %0h want 1", err_cnt); end
    ack();
  endtask

  task automatic test_hdr_abandon();
    int p;
    send_hdr(8'h0F, 16'd2);
    do_write(16'd20, 8'h10, p);
    send_hdr(8'hC3, 16'd1);
    do_write(16'd21, 8'h20, p);
    send_end(1'b1, 1'b0);
    checks++; if (msg_valid !== 1'b1) begin errors++; $display("FAIL abn_valid: got %0h want 1", msg_valid); end
    checks++; if (msg_flag !== 8'hC3) begin errors++; $display("FAIL abn_flag: got %0h want c3", msg_flag); end
    checks++; if (msg_len !== 16'd1) begin errors++; $display("FAIL abn_len: got %0h want 1", msg_len); end
    checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL abn_err: got %0h want 2", err_cnt); end
    ack();
  endtask

  task automatic test_same_cycle_end();
    int p;
    send_hdr(8'h81, 16'd2);
    do_write(16'd30, 8'hA1, p);
    rx_addr = 16'd31; rx_data = 8'hB2; rx_req_wr = 1'b1;
    rx_end = 1'b1; rx_right = 1'b1; rx_line = 1'b1;
    tick();
    rx_req_wr = 1'b0; rx_end = 1'b0; rx_right = 1'b0; rx_line = 1'b0;
    checks++; if (rx_rdy_wr !== 1'b1) begin errors++; $display("FAIL same_rdy: got %0h want 1", rx_rdy_wr); end
    checks++; if (msg_valid !== 1'b1) begin errors++; $display("FAIL same_valid: got %0h want 1", msg_valid); end
    checks++; if (msg_len !== 16'd2) begin errors++; $display("FAIL same_len: got %0h want 2", msg_len); end
    rd(8'd31);
    checks++; if (host_rd_data !== 8'hB2) begin errors++; $display("FAIL same_rd: got %0h want b2", host_rd_data); end
    ack();
  endtask

  task automatic test_bad_addr();
    int p;
    send_hdr(8'h00, 16'd1);
    do_write(16'h0100, 8'h55, p);
    checks++; if (p != 1) begin errors++; $display("FAIL badaddr_pulse: got %0d want 1", p); end
    send_end(1'b1, 1'b0);
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL badaddr_valid: got %0h want 0", msg_valid); end
    checks++; if (err_cnt !== 8'd3) begin errors++; $display("FAIL badaddr_err: got %0h want 3", err_cnt); end
    rd(8'd0);
    checks++; if (host_rd_data !== 8'h11) begin errors++; $display("FAIL badaddr_alias: got %0h want 11", host_rd_data); end
  endtask

  task automatic test_rd_during_wr();
    int p;
    send_hdr(8'h12, 16'd2);
    do_write(16'd40, 8'h01, p);
    host_rd_addr = 8'd40;
    rx_addr = 16'd40; rx_data = 8'h02; rx_req_wr = 1'b1;
    tick();
    checks++; if (host_rd_data !== 8'h01) begin errors++; $display("FAIL rdw_old: got %0h want 01", host_rd_data); end
    rx_req_wr = 1'b0;
    tick();
    checks++; if (host_rd_data !== 8'h02) begin errors++; $display("FAIL rdw_new: got %0h want 02", host_rd_data); end
    send_end(1'b1, 1'b0);
    checks++; if (msg_len !== 16'd2) begin errors++; $display("FAIL rdw_len: got %0h want 2", msg_len); end
    ack();
  endtask

  task automatic test_max_len();
    int p, tot;
    tot = 0;
    send_hdr(8'hEE, 16'd256);
    for (int i = 0; i < 256; i++) begin
      do_write(16'(i), 8'(i) ^ 8'hA5, p);
      tot += p;
    end
    send_end(1'b1, 1'b0);
    checks++; if (msg_valid !== 1'b1) begin errors++; $display("FAIL max_valid: got %0h want 1", msg_valid); end
    checks++; if (msg_len !== 16'h0100) begin errors++; $display("FAIL max_len: got %0h want 100", msg_len); end
    rd(8'd200);
    checks++; if (host_rd_data !== 8'h6D) begin errors++; $display("FAIL max_rd: got %0h want 6d", host_rd_data); end
    ack();
    send_hdr(8'hEF, 16'd256);
    for (int i = 0; i < 256; i++) begin
      do_write(16'(i), 8'(i) ^ 8'h5A, p);
      tot += p;
    end
    do_write(16'd0, 8'hEE, p);
    tot += p;
    checks++; if (tot != 513) begin errors++; $display("FAIL max_pulses: got %0d want 513", tot); end
    rd(8'd0);
    checks++; if (host_rd_data !== 8'h5A) begin errors++; $display("FAIL max_nowrite: got %0h want 5a", host_rd_data); end
    send_end(1'b1, 1'b0);
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL max_reject: got %0h want 0", msg_valid); end
    checks++; if (err_cnt !== 8'd4) begin errors++; $display("FAIL max_err: got %0h want 4", err_cnt); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      send_hdr(8'h01, 16'd1);
      send_end(1'b0, 1'b0);
    end
    checks++; if (err_cnt !== 8'hFF) begin errors++; $display("FAIL sat_err: got %0h want ff", err_cnt); end
  endtask

  task automatic test_reset_mid();
    int p;
    send_hdr(8'h99, 16'd1);
    do_write(16'd50, 8'h77, p);
    host_rd_addr = 8'd50;
    rst_l = 1'b0;
    tick();
    checks++; if (rx_rdy_wr !== 1'b0) begin errors++; $display("FAIL mid_rdy: got %0h want 0", rx_rdy_wr); end
    checks++; if (msg_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0h want 0", msg_valid); end
    checks++; if (msg_flag !== 8'h00) begin errors++; $display("FAIL mid_flag: got %0h want 0", msg_flag); end
    checks++; if (msg_len !== 16'h0000) begin errors++; $display("FAIL mid_len: got %0h want 0", msg_len); end
    checks++; if (msg_line !== 1'b0) begin errors++; $display("FAIL mid_line: got %0h want 0", msg_line); end
    checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL mid_err: got %0h want 0", err_cnt); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_ovr: got %0h want 0", overrun); end
    checks++; if (host_rd_data !== 8'h00) begin errors++; $display("FAIL mid_rdata: got %0h want 0", host_rd_data); end
    rst_l = 1'b1;
    tick();
    checks++; if (host_rd_data !== 8'h77) begin errors++; $display("FAIL mid_buf_kept: got %0h want 77", host_rd_data); end
    send_end(1'b1, 1'b0);
    checks++; if (err_cnt !== 8'h00) begin errors++; $display("FAIL mid_idle_end: got %0h want 0", err_cnt); end
  endtask

  initial begin
    rst_l = 1'b0; rx_flag = '0; rx_byte_number = '0; rx_hdr_en = 1'b0;
    rx_req_wr = 1'b0; rx_addr = '0; rx_data = '0; rx_end = 1'b0;
    rx_right = 1'b0; rx_line = 1'b0; host_rd_addr = '0; host_ack = 1'b0;
    test_reset();
    test_good_msg();
    test_len_mismatch();
    test_held_req();
    test_overrun();
    test_hdr_abandon();
    test_same_cycle_end();
    test_bad_addr();
    test_rd_during_wr();
    test_max_len();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slave_rx_sink.md
SLAVE_RX_SINK -- requirements
Module: slave_rx_sink

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: message buffer is 2**ADDR_W bytes.
REQ-002 SHALL have parameter MAX_LEN, default 256: largest accepted header byte count.
REQ-003 SHALL have one clock, clk (rising edge), and a synchronous active-low reset, rst_l; there is no other clock or reset.
REQ-004 Ports, in order: clk in 1 clock; rst_l in 1 sync active-low reset.
REQ-005 Receiver-side ports: rx_flag in 8 message status; rx_byte_number in 16 header byte count; rx_hdr_en in 1 header-valid strobe.
REQ-006 Write-request ports: rx_req_wr in 1 write request (level); rx_rdy_wr out 1 write done; rx_addr in 16 write address; rx_data in 8 write data.
REQ-007 End-of-message ports: rx_end in 1 end-of-message strobe; rx_right in 1 message CRC/format ok; rx_line in 1 receiving line (0 = COM1, 1 = COM2).
REQ-008 Host ports: host_rd_addr in ADDR_W read address; host_rd_data out 8 read data; host_ack in 1 release the committed message.
REQ-009 Status ports: msg_valid out 1 committed message available; msg_flag out 8; msg_len out 16; msg_line out 1; err_cnt out 8 rejected-message counter; overrun out 1 sticky drop flag.

Function
REQ-010 State machine SHALL have states IDLE, RECV, WRITE and HOLD.
REQ-011 IDLE: rx_hdr_en=1 SHALL latch rx_flag and rx_byte_number, clear the write counter wr_cnt and the bad flag, and go to RECV.
REQ-012 RECV: rx_req_wr=1 with armed=1 SHALL write rx_data to mem[rx_addr[ADDR_W-1:0]], increment wr_cnt, clear armed and go to WRITE.
REQ-013 WRITE: SHALL pulse rx_rdy_wr high for exactly one cycle (one cycle after acceptance) and return to RECV.
REQ-014 armed SHALL be set whenever rx_req_wr is sampled 0, so one request level produces exactly one write and one rx_rdy_wr.
REQ-015 rx_addr >= 2**ADDR_W, or wr_cnt already at MAX_LEN: the block SHALL NOT write mem, SHALL still pulse rx_rdy_wr, and SHALL set bad.
REQ-016 rx_end in RECV or WRITE: commit when rx_right=1, bad=0 and wr_cnt equals the latched byte count; otherwise reject.
REQ-017 Commit SHALL load msg_flag, msg_len (wr_cnt), msg_line (rx_line), set msg_valid, and go to HOLD.
REQ-018 Reject SHALL increment err_cnt, saturating at 8'hFF, and return to IDLE; msg_* SHALL be unchanged.
REQ-019 rx_end and rx_req_wr in the same cycle: the write SHALL complete (mem write and rx_rdy_wr) and count toward wr_cnt before the commit check.
REQ-020 HOLD: rx_hdr_en or rx_req_wr SHALL set overrun; requests SHALL still receive rx_rdy_wr with no mem write, so the receiver never stalls.
REQ-021 HOLD: rx_end SHALL be ignored except for incrementing err_cnt.
REQ-022 host_ack in HOLD SHALL clear msg_valid and go to IDLE; host_ack in any other state SHALL be ignored.
REQ-023 rx_hdr_en in RECV (header with no rx_end) SHALL abandon the current message, increment err_cnt, and restart per REQ-011.
REQ-024 host_rd_data SHALL equal mem[host_rd_addr] one cycle after the address is presented (registered read).
REQ-025 A same-cycle write and read of the same address SHALL return the old data.
REQ-026 overrun SHALL be sticky and clear only on reset.
REQ-027 wr_cnt SHALL be 16 bits and SHALL NOT wrap; it holds at MAX_LEN.

Reset
REQ-028 rst_l=0 at a clock edge SHALL force: state IDLE, rx_rdy_wr 0, msg_valid 0, msg_flag 0, msg_len 0, msg_line 0, err_cnt 0, overrun 0, armed 1, host_rd_data 0.
REQ-029 Buffer contents SHALL NOT be reset.
REQ-030 Reset mid-message SHALL discard the message without incrementing err_cnt.

Verification
REQ-031 Good message: header flag 8'h5A, count 4, writes 11/22/33/44 to addresses 0-3, rx_end with rx_right=1, rx_line=1 -> msg_valid=1, msg_len=4, msg_flag=8'h5A, msg_line=1, and host reads return 11/22/33/44.
REQ-032 Length mismatch: header count 4, 3 writes, rx_end with rx_right=1 -> msg_valid=0, err_cnt=1.
REQ-033 Held request: rx_req_wr high for 5 cycles -> exactly one rx_rdy_wr pulse (at cycle 2) and wr_cnt=1.
REQ-034 Overrun: message committed, no host_ack, second header plus 2 writes -> two rx_rdy_wr pulses, overrun=1, buffer unchanged; host_ack -> IDLE.
REQ-035 Saturation and reset: 300 bad messages -> err_cnt=8'hFF; rst_l=0 in RECV -> all outputs at reset values next cycle.
